// File: rtl/div_result_display_if.sv
// Result/display bundle between the upstream divider and the display driver.
// The master drives the divider result; the slave drives the LED digit outputs.
interface div_result_display_if;
  logic       done;
  logic [3:0] q;
  logic [3:0] r;
  logic       err;
  logic       clr;
  logic [3:0] an;
  logic [6:0] seg;
  logic       valid;

  modport master (
    output done, q, r, err, clr,
    input  an, seg, valid
  );

  modport slave (
    input  done, q, r, err, clr,
    output an, seg, valid
  );
endinterface

// File: rtl/div_result_display.sv
// Captures a 4-bit quotient/remainder on the rising edge of done and scans it onto a
// 4-digit active-low 7-segment display. Define DIV_DISP_LZB_EN to blank zero tens digits.
//
// Handshake: done is edge-qualified. A result is taken only on a cycle where done=1
// after done was sampled low (including after reset), so a held level captures once.
// clr wins over a simultaneous capture. valid stays high until clr or reset.
module div_result_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic                clk,
  input logic                rst,
  div_result_display_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  logic             done_d;
  logic             armed;
  logic             capture;
  logic [3:0]       q_reg;
  logic [3:0]       r_reg;
  logic             err_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;

  logic [3:0]       q_tens, q_ones, r_tens, r_ones;
  logic [6:0]       next_seg;
  logic [3:0]       next_an;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] tens_of(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  // Tens digits may be suppressed when zero; ones digits always show.
  function automatic logic [6:0] tens_seg(input logic [3:0] t);
`ifdef DIV_DISP_LZB_EN
    return (t == 4'd0) ? SEG_BLANK : digit_seg(t);
`else
    return digit_seg(t);
`endif
  endfunction

  // Only the first done-high cycle after a low sample is a capture.
  assign capture = bus.done & ~done_d & armed;

  always_comb begin
    q_tens   = tens_of(q_reg);
    q_ones   = ones_of(q_reg);
    r_tens   = tens_of(r_reg);
    r_ones   = ones_of(r_reg);
    next_seg = SEG_BLANK;
    next_an  = 4'b1111;
    if (valid_reg) begin
      next_an = ~(4'b0001 << digit_idx);
      if (err_reg) begin
        case (digit_idx)
          2'd3:    next_seg = SEG_E;
          2'd2:    next_seg = SEG_R;
          2'd1:    next_seg = SEG_R;
          default: next_seg = SEG_BLANK;
        endcase
      end else begin
        case (digit_idx)
          2'd3:    next_seg = tens_seg(q_tens);
          2'd2:    next_seg = digit_seg(q_ones);
          2'd1:    next_seg = tens_seg(r_tens);
          default: next_seg = digit_seg(r_ones);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_d      <= 1'b0;
      armed       <= 1'b0;
      q_reg       <= 4'd0;
      r_reg       <= 4'd0;
      err_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      an_reg      <= 4'b1111;
      seg_reg     <= SEG_BLANK;
    end else begin
      done_d <= bus.done;
      if (!bus.done) begin
        armed <= 1'b1;
      end

      if (bus.clr) begin
        q_reg     <= 4'd0;
        r_reg     <= 4'd0;
        err_reg   <= 1'b0;
        valid_reg <= 1'b0;
      end else if (capture) begin
        q_reg     <= bus.q;
        r_reg     <= bus.r;
        err_reg   <= bus.err;
        valid_reg <= 1'b1;
      end

      // Scan timing runs freely, independent of capture and clear.
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      an_reg  <= next_an;
      seg_reg <= next_seg;
    end
  end

  assign bus.an    = an_reg;
  assign bus.seg   = seg_reg;
  assign bus.valid = valid_reg;

endmodule

// File: tb/tb_div_result_display.sv
// Directed bench for div_result_display with REFRESH_DIV=4: table of captured results
// with hand-computed digit codes, plus sequences for held done, clr priority and reset.
module tb_div_result_display;

  localparam int unsigned REFRESH_DIV = 4;
`ifdef DIV_DISP_LZB_EN
  localparam logic [6:0] TZ = 7'h7F;
`else
  localparam logic [6:0] TZ = 7'h40;
`endif

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
    logic [6:0] e3;
    logic [6:0] e2;
    logic [6:0] e1;
    logic [6:0] e0;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_result_display_if ifc ();

  div_result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_an"}, 32'(ifc.an), 32'hF);
    check({name, "_seg"}, 32'(ifc.seg), 32'h7F);
    check({name, "_valid"}, 32'(ifc.valid), 32'h0);
  endtask

  // Watch n cycles of scanning: the lit digit must carry its expected code, digits
  // advance 0->1->2->3 and every complete digit period lasts REFRESH_DIV cycles.
  task automatic scan(input int n, input logic [6:0] e3, input logic [6:0] e2,
                      input logic [6:0] e1, input logic [6:0] e0, input string name);
    int prev_idx;
    int run;
    int first;
    int idx;
    logic [6:0] exp;
    prev_idx = -1;
    run = 0;
    first = 1;
    for (int c = 0; c < n; c++) begin
      tick();
      case (ifc.an)
        4'b0111: begin idx = 3; exp = e3; end
        4'b1011: begin idx = 2; exp = e2; end
        4'b1101: begin idx = 1; exp = e1; end
        4'b1110: begin idx = 0; exp = e0; end
        default: begin idx = -1; exp = 7'h7F; end
      endcase
      check({name, "_an_onehot"}, 32'(idx >= 0), 32'h1);
      check({name, "_seg"}, 32'(ifc.seg), 32'(exp));
      if (prev_idx >= 0 && idx != prev_idx) begin
        check({name, "_order"}, 32'(idx), 32'((prev_idx + 1) % 4));
        if (!first) check({name, "_hold"}, 32'(run), 32'(REFRESH_DIV));
        first = 0;
        run = 1;
      end else begin
        run++;
      end
      prev_idx = idx;
    end
  endtask

  task automatic pulse_done(input logic [3:0] q, input logic [3:0] r, input logic err);
    ifc.done = 1'b1;
    ifc.q    = q;
    ifc.r    = r;
    ifc.err  = err;
    tick();
    ifc.done = 1'b0;
    ifc.q    = 4'hA;
    ifc.r    = 4'h5;
    ifc.err  = 1'b0;
  endtask

  task automatic do_clr(input string name);
    ifc.clr = 1'b1;
    tick();
    ifc.clr = 1'b0;
    check({name, "_valid"}, 32'(ifc.valid), 32'h0);
    tick();
    check_idle(name);
  endtask

  vec_t vecs[8];

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    ifc.done = 1'b0;
    ifc.q    = 4'd0;
    ifc.r    = 4'd0;
    ifc.err  = 1'b0;
    ifc.clr  = 1'b0;

    vecs[0] = '{q: 4'd13, r: 4'd2,  err: 1'b0, e3: 7'h79, e2: 7'h30, e1: TZ,    e0: 7'h24};
    vecs[1] = '{q: 4'd15, r: 4'd15, err: 1'b0, e3: 7'h79, e2: 7'h12, e1: 7'h79, e0: 7'h12};
    vecs[2] = '{q: 4'd0,  r: 4'd0,  err: 1'b0, e3: TZ,    e2: 7'h40, e1: TZ,    e0: 7'h40};
    vecs[3] = '{q: 4'd9,  r: 4'd10, err: 1'b0, e3: TZ,    e2: 7'h10, e1: 7'h79, e0: 7'h40};
    vecs[4] = '{q: 4'd7,  r: 4'd4,  err: 1'b0, e3: TZ,    e2: 7'h78, e1: TZ,    e0: 7'h19};
    vecs[5] = '{q: 4'd5,  r: 4'd3,  err: 1'b1, e3: 7'h06, e2: 7'h2F, e1: 7'h2F, e0: 7'h7F};
    vecs[6] = '{q: 4'd8,  r: 4'd6,  err: 1'b0, e3: TZ,    e2: 7'h00, e1: TZ,    e0: 7'h02};
    vecs[7] = '{q: 4'd11, r: 4'd1,  err: 1'b0, e3: 7'h79, e2: 7'h79, e1: TZ,    e0: 7'h79};

    // Held in reset, then idle for 100 cycles with no done
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("in_reset");
    end
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_idle("idle_after_reset");
    end

    // Table: capture each result, verify the scan, then clear
    for (int v = 0; v < 8; v++) begin
      pulse_done(vecs[v].q, vecs[v].r, vecs[v].err);
      check($sformatf("vec%0d_valid", v), 32'(ifc.valid), 32'h1);
      tick();
      scan(22, vecs[v].e3, vecs[v].e2, vecs[v].e1, vecs[v].e0, $sformatf("vec%0d", v));
      do_clr($sformatf("vec%0d_clr", v));
    end

    // Held done: only the first value is taken
    ifc.done = 1'b1;
    ifc.q    = 4'd3;
    ifc.r    = 4'd1;
    tick();
    check("held_valid", 32'(ifc.valid), 32'h1);
    for (int i = 0; i < 5; i++) tick();
    ifc.q = 4'd9;
    ifc.r = 4'd12;
    scan(24, TZ, 7'h30, TZ, 7'h79, "held");
    for (int i = 0; i < 20; i++) tick();
    ifc.done = 1'b0;
    scan(8, TZ, 7'h30, TZ, 7'h79, "held_after");

    // clr and a done rising edge in the same cycle: clr wins
    ifc.clr  = 1'b1;
    ifc.done = 1'b1;
    ifc.q    = 4'd7;
    tick();
    ifc.clr = 1'b0;
    check("clr_prio_valid", 32'(ifc.valid), 32'h0);
    tick();
    check_idle("clr_prio");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("clr_prio_hold");
    end
    ifc.done = 1'b0;
    tick();

    // Reset mid-display of 15/15 with done held through release
    ifc.done = 1'b1;
    ifc.q    = 4'd15;
    ifc.r    = 4'd15;
    tick();
    check("rst_mid_valid_before", 32'(ifc.valid), 32'h1);
    tick();
    scan(7, 7'h79, 7'h12, 7'h79, 7'h12, "rst_mid_scan");
    #2;
    rst = 1'b0;
    #1;
    check_idle("rst_async");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rst_held");
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("release_done_high");
    end
    ifc.done = 1'b0;
    tick();
    pulse_done(4'd2, 4'd5, 1'b0);
    check("post_reset_capture_valid", 32'(ifc.valid), 32'h1);
    tick();
    scan(20, TZ, 7'h24, TZ, 7'h12, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_result_display.md
DIV_RESULT_DISPLAY -- requirements
Module: div_result_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays selected (legal range 2..2^20).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 done  input  1  completion flag from the upstream divider; may be a pulse or a held level.
REQ-005 q  input  4  quotient from the divider, unsigned 0..15.
REQ-006 r  input  4  remainder from the divider, unsigned 0..15.
REQ-007 err  input  1  divide-by-zero flag, sampled with q/r; tie 0 if unused.
REQ-008 clr  input  1  synchronous display clear.
REQ-009 an  output  4  digit enables, active-low, an[3] leftmost.
REQ-010 seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
REQ-011 valid  output  1  high while a captured result is being displayed.

Function
REQ-012 The block SHALL register done into done_d every cycle and detect capture as done=1 and done_d=0.
REQ-013 On capture, the block SHALL load q_reg<=q, r_reg<=r, err_reg<=err and set valid=1 on the same clock edge.
REQ-014 A held done level SHALL cause exactly one capture, and a new capture SHALL require done to return low first.
REQ-015 When clr=1, the block SHALL clear valid, q_reg, r_reg and err_reg on the next edge, and clr SHALL take priority over a simultaneous capture.
REQ-016 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap.
REQ-017 On each counter wrap, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-018 The counter and digit index SHALL be unaffected by capture and clr.
REQ-019 The block SHALL split each 4-bit value into BCD with tens=(v>=10) and ones=v-10*tens.
REQ-020 Digit mapping SHALL be: index 3 = q tens, index 2 = q ones, index 1 = r tens, index 0 = r ones.
REQ-021 With err_reg=1, digits 3..0 SHALL show "E","r","r",blank regardless of q_reg and r_reg.
REQ-022 Segment codes (hex of seg) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, E=06, r=2F, blank=7F.
REQ-023 an and seg SHALL be registered, and SHALL reflect the digit index and display registers one cycle after they change.
REQ-024 For the selected digit, an SHALL have only bit[index] low while valid=1.
REQ-025 While valid=0, an SHALL be 4'b1111 and seg SHALL be 7'h7F.
REQ-026 The maximum value q=15, r=15 SHALL display "1515" with no overflow.

Reset
REQ-027 While rst=0, the block SHALL hold: an=4'b1111, seg=7'h7F, valid=0, q_reg=r_reg=0, err_reg=0, done_d=0, counter=0, digit index=0.
REQ-028 Reset asserted mid-scan or mid-capture SHALL abandon all state immediately.
REQ-029 After reset release, the first capture SHALL require a done rising edge, and a done already high at release SHALL NOT capture.

Configuration
REQ-030 With macro DIV_DISP_LZB_EN defined, a tens digit equal to 0 SHALL display blank (7F), for both q and r, when err_reg=0.
REQ-031 Without DIV_DISP_LZB_EN, tens digits equal to 0 SHALL display "0" (40).

Verification (REFRESH_DIV=4)
REQ-032 Reset release, no done -> an=1111 and seg=7F for 100 cycles, and valid=0.
REQ-033 done pulse with q=13, r=2 -> valid=1, and the scan shows an=0111:seg=79, 1011:30, 1101:40 (7F if LZB), 1110:24, with each digit held 4 cycles.
REQ-034 done held high 50 cycles while q changes 3->9 -> only q=3 is captured, and the display is unchanged.
REQ-035 done pulse with err=1 and q=5 -> scan shows 06, 2F, 2F, 7F.
REQ-036 clr and a done rising edge in the same cycle -> valid=0, and outputs return to 1111/7F.
REQ-037 rst=0 asserted mid-display of q=15, r=15 -> outputs go to 1111/7F asynchronously, and no capture occurs after release while done stays high.
